// File: rtl/max3_arbiter_if.sv
// Handshake bundle for max3_arbiter: two requester ports and one result port.
// Valid/ready rule on every port: a transfer happens on a rising clock edge
// exactly when valid and ready are both high; the source holds valid and its
// payload stable until that edge, and ready never depends on a future cycle.
interface max3_arbiter_if #(
  parameter int DW = 8
);
  logic          req0_valid;
  logic          req0_ready;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic [DW-1:0] req0_c;
  logic          req1_valid;
  logic          req1_ready;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic [DW-1:0] req1_c;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_sel;
  logic          res_id;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_c,
    input  req1_valid, req1_a, req1_b, req1_c,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_sel, res_id
  );

  // Requester/consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_c,
    output req1_valid, req1_a, req1_b, req1_c,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_sel, res_id
  );
endinterface

// File: rtl/max3_arbiter.sv
// max3_arbiter: two requesters share one 2-stage elastic max-of-3 pipeline.
// Stage 1 holds max(a,b) with its index plus c; stage 2 holds the final
// maximum, the winning operand index (lower index wins ties) and the ID.
// Build option: MAX3_ARB_FIXED_PRIO_EN gives requester 0 fixed priority;
// when undefined the arbiter alternates on contention (round-robin).
module max3_arbiter #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  max3_arbiter_if.slave bus,
  output logic          busy
);

  logic          v1_q, v1_d;
  logic [DW-1:0] m_ab_q, m_ab_d;
  logic          sel_ab_q, sel_ab_d;
  logic [DW-1:0] c_q, c_d;
  logic          id_q, id_d;

  logic          res_valid_q, res_valid_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic [1:0]    res_sel_q, res_sel_d;
  logic          res_id_q, res_id_d;

  logic          gnt_id;
  logic          s2_load;
  logic          space;
  logic          ready0;
  logic          ready1;
  logic          accept;
  logic [DW-1:0] op_a, op_b, op_c;

`ifndef MAX3_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif

  // Grant selection and ready generation from valids, priority and space
  always_comb begin
`ifdef MAX3_ARB_FIXED_PRIO_EN
    gnt_id = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = ~bus.req0_valid;
    end
`endif
    s2_load = ~res_valid_q | bus.res_ready;
    space   = ~v1_q | s2_load;
    ready0  = ~reset & space & bus.req0_valid & ~gnt_id;
    ready1  = ~reset & space & bus.req1_valid & gnt_id;
    accept  = ready0 | ready1;
    op_a    = gnt_id ? bus.req1_a : bus.req0_a;
    op_b    = gnt_id ? bus.req1_b : bus.req0_b;
    op_c    = gnt_id ? bus.req1_c : bus.req0_c;
  end

  // Stage 1: loads on acceptance, otherwise holds while stalled
  always_comb begin
    v1_d     = v1_q;
    m_ab_d   = m_ab_q;
    sel_ab_d = sel_ab_q;
    c_d      = c_q;
    id_d     = id_q;
    if (space) begin
      v1_d = accept;
    end
    if (accept) begin
      if (op_a >= op_b) begin
        m_ab_d   = op_a;
        sel_ab_d = 1'b0;
      end else begin
        m_ab_d   = op_b;
        sel_ab_d = 1'b1;
      end
      c_d  = op_c;
      id_d = gnt_id;
    end
  end

  // Stage 2: takes stage 1 whenever it is empty or its result is consumed
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_sel_d   = res_sel_q;
    res_id_d    = res_id_q;
    if (s2_load) begin
      res_valid_d = v1_q;
      if (v1_q) begin
        if (m_ab_q >= c_q) begin
          res_data_d = m_ab_q;
          res_sel_d  = {1'b0, sel_ab_q};
        end else begin
          res_data_d = c_q;
          res_sel_d  = 2'd2;
        end
        res_id_d = id_q;
      end
    end
  end

`ifndef MAX3_ARB_FIXED_PRIO_EN
  // Priority pointer follows the last accepted requester
  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = gnt_id;
    end
  end

  // Pointer register; reset to 1 so requester 0 wins first contention
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // Pipeline registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      m_ab_q      <= '0;
      sel_ab_q    <= 1'b0;
      c_q         <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= 2'd0;
      res_id_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      m_ab_q      <= m_ab_d;
      sel_ab_q    <= sel_ab_d;
      c_q         <= c_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_sel_q   <= res_sel_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_sel    = res_sel_q;
  assign bus.res_id     = res_id_q;
  assign busy           = v1_q | res_valid_q;

endmodule

// File: tb/tb_max3_arbiter.sv
// Bench for max3_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a slot-occupancy model and a result queue.
module tb_max3_arbiter;

  localparam int DW = 8;

  logic clk;
  logic rst;
  logic busy;

  max3_arbiter_if #(.DW(DW)) bus ();

  max3_arbiter #(.DW(DW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave),
    .busy  (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_mis = 0;

  // ---------------- requester state ----------------
  bit            pend [2];
  logic [DW-1:0] op_a [2];
  logic [DW-1:0] op_b [2];
  logic [DW-1:0] op_c [2];

  // ---------------- reference model ----------------
  // exp_q entries: {id, sel[1:0], data[7:0]}; front is the item at the output
  logic [10:0] exp_q [$];
  bit          out_full;
  bit          mid_full;
  bit          last_id;

  function automatic logic [10:0] ref_result(input logic id, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic [DW-1:0] c);
    int vals [3];
    int best;
    int idx;
    vals[0] = int'(a);
    vals[1] = int'(b);
    vals[2] = int'(c);
    best = vals[0];
    idx  = 0;
    for (int i = 1; i < 3; i++) begin
      if (vals[i] > best) begin
        best = vals[i];
        idx  = i;
      end
    end
    return {id, idx[1:0], best[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input int a, input int b, input int c);
    pend[id] = 1'b1;
    op_a[id] = a[DW-1:0];
    op_b[id] = b[DW-1:0];
    op_c[id] = c[DW-1:0];
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 255;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic apply_inputs(input bit rr);
    bus.req0_valid = pend[0];
    bus.req0_a     = op_a[0];
    bus.req0_b     = op_b[0];
    bus.req0_c     = op_c[0];
    bus.req1_valid = pend[1];
    bus.req1_a     = op_a[1];
    bus.req1_b     = op_b[1];
    bus.req1_c     = op_c[1];
    bus.res_ready  = rr;
  endtask

  // One clock: drive at negedge, check, advance the model at posedge
  task automatic run_cycle(input bit rr);
    bit both, any, g_id, s2load, space, e_r0, e_r1;
    logic [10:0] item;
    apply_inputs(rr);
    #1;
    any  = pend[0] | pend[1];
    both = pend[0] & pend[1];
`ifdef MAX3_ARB_FIXED_PRIO_EN
    g_id = both ? 1'b0 : pend[1];
`else
    g_id = both ? ~last_id : pend[1];
`endif
    s2load = !out_full || rr;
    space  = !mid_full || s2load;
    e_r0   = any && space && (g_id == 1'b0);
    e_r1   = any && space && (g_id == 1'b1);
    chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
    chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
    chk("res_valid", 32'(bus.res_valid), 32'(out_full));
    chk("busy", 32'(busy), 32'(out_full | mid_full));
    if (out_full && exp_q.size() > 0) begin
      item = exp_q[0];
      chk("res_data", 32'(bus.res_data), 32'(item[7:0]));
      chk("res_sel", 32'(bus.res_sel), 32'(item[9:8]));
      chk("res_id", 32'(bus.res_id), 32'(item[10]));
    end
    @(posedge clk);
    if (out_full && rr) void'(exp_q.pop_front());
    if (e_r0 || e_r1) begin
      exp_q.push_back(ref_result(g_id, op_a[g_id], op_b[g_id], op_c[g_id]));
      pend[g_id] = 1'b0;
      last_id    = g_id;
    end
    out_full = s2load ? mid_full : out_full;
    mid_full = space ? (e_r0 | e_r1) : mid_full;
    @(negedge clk);
  endtask

  // Reset pulse from a negedge; outputs must clear before any clock edge
  task automatic pulse_reset();
    apply_inputs(1'b0);
    rst = 1'b1;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_sel", 32'(bus.res_sel), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    out_full = 1'b0;
    mid_full = 1'b0;
    last_id  = 1'b1;
  endtask

  // ---------------- scenario ----------------
  initial begin
    int sent;
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = '0;
    end
    out_full = 1'b0;
    mid_full = 1'b0;
    last_id  = 1'b1;
    apply_inputs(1'b0);
    @(negedge clk);
    @(negedge clk);

    // Reset state with both requesters asking
    set_req(0, 1, 2, 3);
    set_req(1, 4, 5, 6);
    pulse_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    run_cycle(1'b1);

    // Single request, two-cycle latency, busy drops after consumption
    set_req(0, 10, 200, 50);
    for (int i = 0; i < 4; i++) run_cycle(1'b1);

    // Contention starting from a fresh reset: requester 0 first
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      if (!pend[0]) set_req(0, 5, 5, 5);
      if (!pend[1]) set_req(1, 1, 2, 3);
      run_cycle(1'b1);
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle(1'b1);

    // Backpressure: four triples from requester 1, consumer stalled 5 cycles
    sent = 0;
    for (int i = 0; i < 12; i++) begin
      if (!pend[1] && sent < 4) begin
        set_req(1, 10 * sent + 1, 10 * sent + 7, 10 * sent + 3);
        sent++;
      end
      run_cycle(i >= 5);
    end

    // Ties and extremes
    set_req(0, 255, 255, 0);
    run_cycle(1'b1);
    set_req(0, 0, 0, 0);
    run_cycle(1'b1);
    set_req(0, 7, 9, 9);
    run_cycle(1'b1);
    set_req(1, 9, 9, 9);
    for (int i = 0; i < 4; i++) run_cycle(1'b1);

    // Reset with both stages full, then contention goes to requester 0
    set_req(1, 1, 1, 1);
    run_cycle(1'b0);
    set_req(1, 2, 2, 2);
    run_cycle(1'b0);
    set_req(0, 3, 3, 3);
    run_cycle(1'b0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    pulse_reset();
    set_req(0, 40, 30, 20);
    set_req(1, 20, 30, 40);
    for (int i = 0; i < 5; i++) run_cycle(1'b1);

    // Random traffic with occasional withdrawn requests
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 99) < 60) begin
          set_req(r, rnd_val(), rnd_val(), rnd_val());
        end else if (pend[r] && $urandom_range(0, 99) < 4) begin
          pend[r] = 1'b0;
        end
      end
      run_cycle($urandom_range(0, 99) < 65);
    end

    // Drain
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle(1'b1);
    chk("drained_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
